// File: rtl/vector_deserializer_p4.sv
// Serial-to-parallel vector assembler: packs LANES-wide beats into an
// INPUT_SIZE-element vector using two ping-pong banks. Each completed vector
// is presented to the parallel consumer and held stable until it is accepted.
module vector_deserializer_p4 #(
   parameter int unsigned WIDTH      = 17,
   parameter int unsigned INPUT_SIZE = 32,
   parameter int unsigned LANES      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*WIDTH-1:0]      in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [INPUT_SIZE*WIDTH-1:0] out_data,
   output logic                        err_no_last
);

   localparam int unsigned BEATS = (INPUT_SIZE + LANES - 1) / LANES;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned VW    = INPUT_SIZE * WIDTH;

   logic [VW-1:0] bank   [2];
   logic [VW-1:0] bank_n [2];
   logic [1:0]    full, full_n;
   logic          wp, wp_n;
   logic          rp, rp_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic          err_n;
   logic          wr_fire;
   logic          rd_fire;
   logic          vec_done;

   // Next-state: release the read bank, write the beat, close the vector.
   // Banks are zeroed on release, so an early in_last leaves the unwritten
   // tail at 0 without any extra clearing.
   always_comb begin
      bank_n   = bank;
      full_n   = full;
      wp_n     = wp;
      rp_n     = rp;
      bcnt_n   = bcnt;
      err_n    = 1'b0;
      wr_fire  = in_valid && in_ready;
      rd_fire  = out_valid && out_ready;
      vec_done = wr_fire && (in_last || (bcnt == BW'(BEATS - 1)));

      if (rd_fire) begin
         full_n[rp] = 1'b0;
         bank_n[rp] = '0;
         rp_n       = ~rp;
      end

      if (wr_fire) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            if ((32'(bcnt) * LANES + k) < INPUT_SIZE)
               bank_n[wp][(32'(bcnt) * LANES + k) * WIDTH +: WIDTH] = in_data[k * WIDTH +: WIDTH];
         end
         bcnt_n = bcnt + BW'(1);
      end

      if (vec_done) begin
         full_n[wp] = 1'b1;
         wp_n       = ~wp;
         bcnt_n     = '0;
         err_n      = !in_last;
      end
   end

   // State and registered outputs, derived from the next state so the
   // handshakes reflect this edge's transfers one cycle later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bank[0]     <= '0;
         bank[1]     <= '0;
         full        <= '0;
         wp          <= 1'b0;
         rp          <= 1'b0;
         bcnt        <= '0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         err_no_last <= 1'b0;
      end else begin
         bank        <= bank_n;
         full        <= full_n;
         wp          <= wp_n;
         rp          <= rp_n;
         bcnt        <= bcnt_n;
         in_ready    <= !full_n[wp_n];
         out_valid   <= full_n[rp_n];
         out_data    <= bank_n[rp_n];
         err_no_last <= err_n;
      end
   end

endmodule

// File: tb/tb_vector_deserializer_p4.sv
// Bench for vector_deserializer_p4: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of completed vectors.
module tb_vector_deserializer_p4;

   localparam int unsigned W  = 17;
   localparam int unsigned N  = 32;
   localparam int unsigned L  = 4;
   localparam int unsigned B  = 8;
   localparam int unsigned N2 = 30;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid, in_ready, in_last, out_valid, out_ready, err_no_last;
   logic [L*W-1:0] in_data;
   logic [N*W-1:0] out_data;

   logic            b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_err;
   logic [L*W-1:0]  b_in_data;
   logic [N2*W-1:0] b_out_data;

   int checks = 0;
   int errors = 0;

   // model state
   logic [N*W-1:0] pend[$];
   logic [N*W-1:0] cur;
   int             cur_b;
   logic           e_err;
   logic           e_rst;
   logic           last_acc;
   int             err_seen;

   always #5 clk = ~clk;

   vector_deserializer_p4 #(.WIDTH(W), .INPUT_SIZE(N), .LANES(L)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .err_no_last(err_no_last));

   vector_deserializer_p4 #(.WIDTH(W), .INPUT_SIZE(N2), .LANES(L)) dut30 (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .err_no_last(b_err));

   task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [L*W-1:0] beat_vals(input int base, input bit neg);
      logic [L*W-1:0] d;
      for (int k = 0; k < int'(L); k++)
         d[k*W +: W] = neg ? W'(-(base + k)) : W'(base + k);
      return d;
   endfunction

   // One clock of the model, then compare the DUT right after the edge.
   task automatic step();
      logic rel, acc;
      last_acc = 1'b0;
      if (!reset) begin
         pend.delete();
         cur   = '0;
         cur_b = 0;
         e_err = 1'b0;
         e_rst = 1'b1;
      end else begin
         rel   = (pend.size() > 0) && out_ready;
         acc   = in_valid && !e_rst && (pend.size() < 2);
         e_err = 1'b0;
         if (rel) void'(pend.pop_front());
         if (acc) begin
            for (int k = 0; k < int'(L); k++)
               if (cur_b * int'(L) + k < int'(N))
                  cur[(cur_b * int'(L) + k) * W +: W] = in_data[k*W +: W];
            cur_b++;
            if (in_last || cur_b == int'(B)) begin
               pend.push_back(cur);
               e_err = !in_last;
               cur   = '0;
               cur_b = 0;
            end
         end
         last_acc = acc;
         e_rst    = 1'b0;
      end
      @(posedge clk);
      #1;
      if (err_no_last) err_seen++;
      chk("in_ready", N*W'(in_ready), N*W'(!e_rst && pend.size() < 2));
      chk("out_valid", N*W'(out_valid), N*W'(pend.size() > 0));
      chk("err_no_last", N*W'(err_no_last), N*W'(e_err));
      if (pend.size() > 0) chk("out_data", out_data, pend[0]);
      if (e_rst) chk("rst_out_data", out_data, '0);
   endtask

   task automatic send(input logic [L*W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int t = 0; t < 40; t++) begin
         step();
         if (last_acc) break;
      end
      chk("send_accept", N*W'(last_acc), N*W'(1));
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int sum;
      reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      cur = '0; cur_b = 0; e_err = 1'b0; e_rst = 1'b1; err_seen = 0;
      #1;
      step(); step();
      reset = 1'b1;
      step();

      // 1: full vector 1..32
      out_ready = 1'b1;
      for (int b = 0; b < int'(B); b++) send(beat_vals(b*4 + 1, 1'b0), b == int'(B) - 1);
      sum = 0;
      for (int i = 0; i < int'(N); i++) sum += int'($signed(out_data[i*W +: W]));
      chk("t1_sum", N*W'(sum), N*W'(528));
      chk("t1_valid", N*W'(out_valid), N*W'(1));
      idle(2);

      // 2: early last after three beats
      for (int b = 0; b < 3; b++) send(beat_vals(b*4 + 1, 1'b0), b == 2);
      chk("t2_tail", N*W'(out_data[N*W-1 : 12*W]), '0);
      idle(2);

      // 3: backpressure with three vectors
      out_ready = 1'b0;
      for (int v = 0; v < 2; v++)
         for (int b = 0; b < int'(B); b++) send(beat_vals(v*100 + b*4, 1'b0), b == int'(B) - 1);
      in_valid = 1'b1; in_data = beat_vals(200, 1'b0); in_last = 1'b0;
      step(); step(); step();
      chk("t3_stall", N*W'(in_ready), N*W'(0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_ready_after_release", N*W'(in_ready), N*W'(1));
      step();
      for (int b = 1; b < int'(B); b++) send(beat_vals(200 + b*4, 1'b0), b == int'(B) - 1);
      out_ready = 1'b1;
      idle(4);

      // 4: missing last, then a proper vector
      err_seen = 0;
      for (int b = 0; b < int'(B); b++) send(beat_vals(300 + b*4, 1'b0), 1'b0);
      for (int b = 0; b < int'(B); b++) send(beat_vals(400 + b*4, 1'b0), b == int'(B) - 1);
      idle(2);
      chk("t4_err_pulses", N*W'(err_seen), N*W'(1));

      // 5: reset mid-vector
      for (int b = 0; b < 5; b++) send(beat_vals(500 + b*4, 1'b0), 1'b0);
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      for (int b = 0; b < int'(B); b++) send(beat_vals(600 + b*4, 1'b0), b == int'(B) - 1);
      idle(2);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_last   = ($urandom_range(0, 5) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         for (int k = 0; k < int'(L); k++) in_data[k*W +: W] = W'($urandom);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      idle(4);

      // 6: INPUT_SIZE=30 instance, negative elements, lanes past 30 dropped
      for (int b = 0; b < int'(B); b++) begin
         b_in_valid = 1'b1;
         b_in_data  = beat_vals(b*4 + 1, 1'b1);
         b_in_last  = (b == int'(B) - 1);
         chk("t6_in_ready", N*W'(b_in_ready), N*W'(1));
         @(posedge clk);
         #1;
      end
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      chk("t6_valid", N*W'(b_out_valid), N*W'(1));
      chk("t6_err", N*W'(b_err), N*W'(0));
      for (int i = 0; i < int'(N2); i++)
         chk($sformatf("t6_elem%0d", i), N*W'(b_out_data[i*W +: W]), N*W'(W'(-(i + 1))));
      @(posedge clk);
      #1;
      chk("t6_released", N*W'(b_out_valid), N*W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_deserializer_p4.md
Name: vector_deserializer_p4

Overview:
Serial-to-parallel front end that assembles LANES-wide beats from a streaming source into a full INPUT_SIZE-element vector. It presents the vector, held stable, to a parallel consumer such as the pipelined 4-ary adder tree. It is the producer side of that consumer's parallel input_data interface. Internal ping-pong banks let a new vector fill while the previous one waits for the consumer.

Parameters:
WIDTH, 17, bit width of each signed element
INPUT_SIZE, 32, elements per output vector
LANES, 4, elements accepted per input beat (1..INPUT_SIZE)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (0 = reset)
in_valid  in  1  source has a beat
in_ready  out  1  block can accept a beat
in_data  in  signed [WIDTH-1:0] x LANES  beat elements; lane k maps to vector index beat*LANES+k
in_last  in  1  final beat of the current vector
out_valid  out  1  completed vector available
out_ready  in  1  consumer accepts the vector
out_data  out  signed [WIDTH-1:0] x INPUT_SIZE  assembled vector
err_no_last  out  1  one-cycle pulse: vector hit BEATS beats without in_last

Behaviour:
- BEATS = ceil(INPUT_SIZE/LANES). A beat transfers when in_valid && in_ready.
- Two banks, each with a full flag. Write pointer wp selects the filling bank; read pointer rp selects the bank driven on out_data. A beat counter bcnt runs 0..BEATS-1.
- Handshake outputs are registered: in_ready = !full[wp]; out_valid = full[rp]; out_data = bank[rp].
- Accepted beat: write lanes into bank[wp] at indices bcnt*LANES+k. Lanes whose index is >= INPUT_SIZE are discarded.
- Vector completes on an accepted beat with in_last=1, or when bcnt==BEATS-1.
  - On completion: set full[wp], toggle wp, clear bcnt.
  - Early in_last: every element not yet written in that vector is forced to 0. Banks are zero-cleared when released, so no stale data remains.
  - Completion at bcnt==BEATS-1 with in_last=0: err_no_last=1 for exactly one cycle (the cycle after the beat). The next beat starts a new vector.
- Latency: completing beat accepted at edge N gives out_valid=1 after edge N, i.e. visible in cycle N+1. out_valid is never asserted combinationally from in_valid.
- Output: out_valid && out_ready at an edge clears full[rp], zeroes bank[rp], and toggles rp.
  - While out_valid=1 && out_ready=0, out_data and out_valid hold stable.
- Simultaneous events:
  - A completing write to bank[wp] and a read release of bank[rp] (rp != wp) in the same cycle are both honoured.
  - Both banks full gives in_ready=0. A release in cycle C makes in_ready=1 in cycle C+1.
  - Back-to-back vectors with out_ready held at 1 sustain one beat per cycle with no bubbles.
- Reset (reset=0 at an edge), including mid-vector: wp=rp=0, bcnt=0, both full=0, all bank contents 0, out_valid=0, out_data all 0, err_no_last=0, in_ready=1 in the cycle after reset deasserts. Partial vectors are discarded.
- No arithmetic is performed on the data. Elements pass bit-exact, and sign is preserved.

Test Plan:
1. Defaults, out_ready=1. Send 8 beats carrying values 1..32 with in_last on beat 8 -> out_valid for 1 cycle, starting the cycle after beat 8. out_data[i]=i+1; the adder tree downstream sums it to 528. err_no_last stays 0.
2. Early last. Send 3 beats (1..12) with in_last on beat 3 -> out_data[0..11]=1..12, out_data[12..31]=0.
3. Backpressure. Hold out_ready=0 and stream 3 vectors -> first vector's out_data holds stable. in_ready falls after vector 2 completes, and beat 1 of vector 3 stalls. Raise out_ready for 1 cycle -> vector 1 released; vector 2 appears next cycle; in_ready=1 the cycle after the release.
4. Missing last. Send 8 beats with in_last=0 throughout, then 8 more with in_last on beat 8 -> two vectors output. err_no_last pulses once, right after beat 8.
5. Reset mid-vector. Drive reset=0 after 5 beats, then send a clean vector -> no output from the partial vector. The new vector is correct, and all outputs are 0 during reset.
6. INPUT_SIZE=30, LANES=4, elements -1..-30 (negative values) -> BEATS=8. Beat 8 lanes 2..3 are discarded; out_data[i]=-(i+1), checking that sign is preserved.
